// File: rtl/vec_mul_pp_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : vec_mul_pkg
// Desc   : Mode/state encodings and step-schedule helpers for the iterative
//          SIMD byte multiplier.
// Rev    : 1.0
// ============================================================================
package vec_mul_pkg;

    typedef enum logic [1:0] {
        MODE_8    = 2'b00,
        MODE_16   = 2'b01,
        MODE_32   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic [4:0] num_steps(input mode_e mode);
        case (mode)
            MODE_8:  return 5'd4;
            MODE_16: return 5'd8;
            MODE_32: return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

    // Returns {i[1:0], j[1:0]}: i selects the a byte, j the b byte.
    function automatic logic [3:0] pair_idx(input mode_e mode, input logic [3:0] step);
        case (mode)
            MODE_8:  return {step[1:0], step[1:0]};
            MODE_16: return {step[2], step[1], step[2], step[0]};
            MODE_32: return step;
            default: return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_mul_pp_sequencer_mul8.sv
`default_nettype none
// ============================================================================
// Module : multiplier_8bit
// Desc   : Unsigned 8x8 -> 16 combinational byte multiplier core.
// Rev    : 1.0
// ============================================================================
module multiplier_8bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    assign p = 16'(a) * 16'(b);

endmodule
`default_nettype wire

// File: rtl/vec_mul_pp_sequencer.sv
`default_nettype none
// ============================================================================
// Module : vec_mul_pp_sequencer
// Desc   : Iterative 4x8/2x16/1x32 unsigned SIMD multiplier stepping byte
//          pairs through one multiplier_8bit. Optional VEC_MUL_ZERO_BYPASS_EN
//          short-circuits operations with a zero operand.
// Rev    : 1.0
// ============================================================================
module vec_mul_pp_sequencer
    import vec_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RES_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_prod,
    output logic              out_err
);

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("vec_mul_pp_sequencer: DATA_W must be 32");
        end
    endgenerate

    state_e            r_state;
    mode_e             r_mode;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_step;
    logic [RES_W-1:0]  r_acc;
    logic              r_err;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [RES_W-1:0]  r_out_prod;
    logic              r_out_err;

    logic [3:0]        w_pair;
    logic [1:0]        w_i;
    logic [1:0]        w_j;
    logic [2:0]        w_ij;
    logic [7:0]        w_a_byte;
    logic [7:0]        w_b_byte;
    logic [15:0]       w_pp;
    logic [RES_W-1:0]  w_shifted;
    logic              w_last;
    logic              w_accept;
    logic              w_bypass;

    assign w_pair    = pair_idx(r_mode, r_step);
    assign w_i       = w_pair[3:2];
    assign w_j       = w_pair[1:0];
    assign w_ij      = {1'b0, w_i} + {1'b0, w_j};
    assign w_a_byte  = r_a[{w_i, 3'b000} +: 8];
    assign w_b_byte  = r_b[{w_j, 3'b000} +: 8];
    assign w_shifted = RES_W'(w_pp) << {w_ij, 3'b000};
    assign w_last    = ({1'b0, r_step} == (num_steps(r_mode) - 5'd1));
    assign w_accept  = in_valid & r_in_ready;

`ifdef VEC_MUL_ZERO_BYPASS_EN
    assign w_bypass = ((in_a == '0) || (in_b == '0)) && (in_mode != MODE_RSVD);
`else
    assign w_bypass = 1'b0;
`endif

    multiplier_8bit u_mul8 (
        .a (w_a_byte),
        .b (w_b_byte),
        .p (w_pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mode      <= MODE_8;
            r_a         <= '0;
            r_b         <= '0;
            r_step      <= '0;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_prod  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_mode     <= mode_e'(in_mode);
                        r_acc      <= '0;
                        r_step     <= '0;
                        r_err      <= (in_mode == MODE_RSVD);
                        r_in_ready <= 1'b0;
                        r_state    <= w_bypass ? DONE : CALC;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    // Lane products never exceed their lane, so a plain add is carry-safe.
                    if (!r_err) begin
                        r_acc <= r_acc + w_shifted;
                    end
                    r_step <= r_step + 4'd1;
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_prod  <= r_err ? '0 : r_acc;
                        r_out_err   <= r_err;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_err   <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_prod  = r_out_prod;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_mul_pp_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_vec_mul_pp_sequencer
// Desc   : Scoreboard bench for vec_mul_pp_sequencer (results and latency).
// Rev    : 1.0
// ============================================================================
module tb_vec_mul_pp_sequencer;

    typedef struct {
        logic [63:0] prod;
        logic        err;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_prod;
    logic        out_err;

    int   r_cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic r_prev_valid = 1'b0;
    exp_t sb[$];

    vec_mul_pp_sequencer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) r_cyc <= r_cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = '0;
        case (m)
            2'b00: for (int k = 0; k < 4; k++) r[16*k +: 16] = a[8*k +: 8] * b[8*k +: 8];
            2'b01: for (int k = 0; k < 2; k++) r[32*k +: 32] = a[16*k +: 16] * b[16*k +: 16];
            2'b10: r = {32'b0, a} * {32'b0, b};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
`ifdef VEC_MUL_ZERO_BYPASS_EN
        if (m != 2'b11 && (a == 0 || b == 0)) return 1;
`endif
        case (m)
            2'b00:   return 5;
            2'b01:   return 9;
            2'b10:   return 17;
            default: return 2;
        endcase
    endfunction

    task automatic drive_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        e.prod    = model(m, a, b);
        e.err     = (m == 2'b11);
        e.acc_cyc = r_cyc;
        e.lat     = exp_latency(m, a, b);
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    // Compare each result on the cycle out_valid rises.
    always @(negedge clk) begin
        if (rst_n && out_valid && !r_prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("prod", out_prod, e.prod);
                check("err", 64'(out_err), 64'(e.err));
                check("latency", 64'(r_cyc - e.acc_cyc), 64'(e.lat));
            end
        end
        r_prev_valid = out_valid;
    end

    initial begin
        int n;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_prod", out_prod, 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        drive_op(2'b00, 32'h04030201, 32'h05050505);
        drive_op(2'b01, 32'hFFFF0002, 32'hFFFF0003);
        drive_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int t = 0; t < 8; t++) begin
            drive_op(2'(t % 4), $urandom, $urandom);
        end

        // Output back-pressure with a competing request held on the input
        drive_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_a      = 32'h11223344;
        in_b      = 32'h55667788;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_prod", out_prod, 64'hFFFFFFFE_00000001);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("no_capture", 64'(out_valid), 64'd0);

        // Asynchronous reset during step 7 of a 32-bit op
        drive_op(2'b10, 32'hDEADBEEF, 32'h12345678);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_prod", out_prod, 64'd0);
        check("abort_out_err", 64'(out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        drive_op(2'b00, 32'h04030201, 32'h05050505);

        // Zero operand and reserved mode
        drive_op(2'b10, 32'h00000000, 32'h12345678);
        drive_op(2'b00, 32'h12345678, 32'h00000000);
        drive_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);

        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
